// File: rtl/fft_pkg.sv
// Shared types and helpers for the block-floating-point FFT stage scaler:
// controller states, the 2-bit shift type and the peak-magnitude classifier.
package fft_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  typedef logic [1:0] shift_t;

  localparam shift_t MAX_SHIFT = 2'd2;

  // 0: fits fit_bits signed bits, 1: fits one bit more, 2: anything larger.
  function automatic shift_t peak_class(input logic signed [31:0] y, input int fit_bits);
    logic signed [31:0] lim0;
    logic signed [31:0] lim1;
    lim0 = 32'sd1 <<< (fit_bits - 1);
    lim1 = lim0 <<< 1;
    if (y >= -lim0 && y < lim0) begin
      return 2'd0;
    end else if (y >= -lim1 && y < lim1) begin
      return 2'd1;
    end
    return MAX_SHIFT;
  endfunction

endpackage

// File: rtl/bfp_round_shift.sv
// Combinational arithmetic right shift by 0..2 with round-half-to-even.
// The extra headroom bit keeps the biased sum from wrapping for any input.
module bfp_round_shift
  import fft_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic signed [DATA_W-1:0] x_i,
  input  shift_t                   shift_i,
  output logic signed [DATA_W-1:0] y_o
);

  logic signed [DATA_W:0] xe;
  logic signed [DATA_W:0] bias;
  logic signed [DATA_W:0] t;

  always_comb begin
    xe   = {x_i[DATA_W-1], x_i};
    bias = '0;
    case (shift_i)
      2'd1:    bias = {{DATA_W{1'b0}}, x_i[1]};
      // 1 + x[2] is 2'b10 when x[2] is set, 2'b01 otherwise
      2'd2:    bias = {{(DATA_W-1){1'b0}}, x_i[2], ~x_i[2]};
      default: bias = '0;
    endcase
    t   = xe + bias;
    y_o = DATA_W'(t >>> shift_i);
  end

endmodule

// File: rtl/fft_bfp_scaler.sv
// Block-floating-point scaler run after each FFT butterfly stage: shifts one
// frame at a time, picks the next frame's shift from the output peak, and
// accumulates the block exponent. Optional build macro FFT_BFP_FORCE_SHIFT_EN
// adds force_en/force_shift to override the peak-derived shift.
module fft_bfp_scaler
  import fft_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int FRAME_LEN  = 64,
  parameter int NUM_STAGES = 6,
  parameter int GUARD      = 2,
  parameter int EXP_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic [1:0]        cur_shift,
  output logic [EXP_W-1:0]  blk_exp,
  output logic              frame_err
`ifdef FFT_BFP_FORCE_SHIFT_EN
  ,
  input  logic              force_en,
  input  logic [1:0]        force_shift
`endif
);

  localparam int FC_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int SC_W = $clog2(NUM_STAGES + 1);
  localparam logic [FC_W-1:0] LAST_IDX    = FC_W'(FRAME_LEN - 1);
  localparam logic [SC_W-1:0] FINAL_STAGE = SC_W'(NUM_STAGES - 1);

  function automatic logic [EXP_W-1:0] sat_add(input logic [EXP_W-1:0] a, input shift_t s);
    logic [EXP_W:0] sum;
    sum = {1'b0, a} + (EXP_W + 1)'(s);
    return sum[EXP_W] ? '1 : sum[EXP_W-1:0];
  endfunction

  state_t                     state_q;
  shift_t                     shift_q, shift_d;
  shift_t                     peak_q, peak_d;
  shift_t                     pc;
  logic [FC_W-1:0]            frame_cnt_q;
  logic [SC_W-1:0]            stage_cnt_q;
  logic [EXP_W-1:0]           blk_exp_q, blk_exp_d;
  logic                       frame_err_q;
  logic                       busy_q;
  logic                       done_q;

  logic                       vld_p1_q, vld_p2_q;
  logic                       last_p1_q, last_p2_q;
  logic signed [DATA_W-1:0]   data_p1_q, data_p2_q;

  logic                       adv;
  logic                       accept;
  logic                       at_last;
  logic signed [DATA_W-1:0]   rnd;

  assign adv      = !vld_p2_q || out_ready;
  assign in_ready = (state_q == RUN) && adv;
  assign accept   = in_valid && in_ready;
  assign at_last  = (frame_cnt_q == LAST_IDX);

  bfp_round_shift #(
    .DATA_W (DATA_W)
  ) u_round (
    .x_i     ($signed(in_data)),
    .shift_i (shift_q),
    .y_o     (rnd)
  );

  // The class of the sample being accepted is folded in now, so the frame's
  // final sample still counts toward the shift chosen at its own boundary.
  always_comb begin
    pc        = peak_class(32'(rnd), DATA_W - GUARD);
    peak_d    = (pc > peak_q) ? pc : peak_q;
    blk_exp_d = sat_add(blk_exp_q, shift_q);
`ifdef FFT_BFP_FORCE_SHIFT_EN
    if (force_en) begin
      shift_d = (force_shift > MAX_SHIFT) ? MAX_SHIFT : force_shift;
    end else begin
      shift_d = peak_d;
    end
`else
    shift_d = peak_d;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      peak_q      <= '0;
      frame_cnt_q <= '0;
      stage_cnt_q <= '0;
      blk_exp_q   <= '0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q     <= RUN;
            busy_q      <= 1'b1;
            shift_q     <= '0;
            peak_q      <= '0;
            frame_cnt_q <= '0;
            stage_cnt_q <= '0;
            blk_exp_q   <= '0;
            frame_err_q <= 1'b0;
          end
        end
        RUN: begin
          if (accept) begin
            // The counter owns frame boundaries; in_last is only cross-checked.
            if (in_last != at_last) begin
              frame_err_q <= 1'b1;
            end
            if (at_last) begin
              shift_q     <= shift_d;
              blk_exp_q   <= blk_exp_d;
              peak_q      <= '0;
              frame_cnt_q <= '0;
              stage_cnt_q <= stage_cnt_q + SC_W'(1);
              if (stage_cnt_q == FINAL_STAGE) begin
                state_q <= DRAIN;
              end
            end else begin
              peak_q      <= peak_d;
              frame_cnt_q <= frame_cnt_q + FC_W'(1);
            end
          end
        end
        DRAIN: begin
          if (!vld_p1_q && !vld_p2_q) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Stage p1: rounded/shifted sample
  always_ff @(posedge clk) begin
    if (accept) begin
      data_p1_q <= rnd;
    end
  end

  // Stage p2: output register; both stages advance together
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1_q  <= 1'b0;
      last_p1_q <= 1'b0;
      vld_p2_q  <= 1'b0;
      last_p2_q <= 1'b0;
      data_p2_q <= '0;
    end else if (adv) begin
      vld_p1_q  <= accept;
      last_p1_q <= accept && in_last;
      vld_p2_q  <= vld_p1_q;
      last_p2_q <= last_p1_q;
      if (vld_p1_q) begin
        data_p2_q <= data_p1_q;
      end
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign out_valid = vld_p2_q;
  assign out_data  = data_p2_q;
  assign out_last  = last_p2_q;
  assign cur_shift = shift_q;
  assign blk_exp   = blk_exp_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_fft_bfp_scaler.sv
// Directed bench for fft_bfp_scaler (default build, FFT_BFP_FORCE_SHIFT_EN undefined).
module tb_fft_bfp_scaler;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic               busy;
  logic               done;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] in_data;
  logic               in_last;
  logic               out_valid;
  logic               out_ready;
  logic signed [15:0] out_data;
  logic               out_last;
  logic [1:0]         cur_shift;
  logic [7:0]         blk_exp;
  logic               frame_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_at = 0;
  int last_hs = 0;
  logic busy_at_done = 1'b0;
  bit rnd_rdy = 1'b0;
  int pat_k = 0;

  int oq[$];
  bit lq[$];
  int sq[$];
  bit slq[$];

  fft_bfp_scaler #(
    .DATA_W(16), .FRAME_LEN(64), .NUM_STAGES(6), .GUARD(2), .EXP_W(8)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .cur_shift(cur_shift), .blk_exp(blk_exp), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Observe just before each rising edge, when all inputs are settled.
  always @(negedge clk) begin
    #4;
    if (!rst && out_valid && out_ready) begin
      oq.push_back(int'(out_data));
      lq.push_back(out_last);
      last_hs = cyc + 1;
    end
    if (done) begin
      done_cnt++;
      done_at = cyc;
      busy_at_done = busy;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive_ready();
    out_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  task automatic send(input int v, input bit last);
    int g;
    g = 0;
    in_valid = 1'b1;
    in_data  = 16'(v);
    in_last  = last;
    sq.push_back(v);
    slq.push_back(last);
    drive_ready();
    #1;
    while (!in_ready && g < 200) begin
      @(negedge clk);
      drive_ready();
      #1;
      g++;
    end
    if (g >= 200) chk("send_ready_timeout", in_ready, 1);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send_frame(input int h0, input int h1, input int h2, input int h3, input bit pat);
    int v;
    for (int i = 0; i < 64; i++) begin
      if (pat) begin
        v = ((pat_k * 37) % 4000) - 2000;
        pat_k++;
      end else begin
        case (i)
          0:       v = h0;
          1:       v = h1;
          2:       v = h2;
          3:       v = h3;
          default: v = 0;
        endcase
      end
      send(v, i == 63);
    end
  endtask

  task automatic start_xfer();
    oq.delete(); lq.delete(); sq.delete(); slq.delete();
    done_cnt = 0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int g;
    int nlast;
    int bad;
    g = 0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    while (done_cnt == 0 && g < 500) begin
      @(negedge clk);
      drive_ready();
      g++;
    end
    out_ready = 1'b1;
    repeat (4) @(negedge clk);
    chk($sformatf("%s_out_count", tag), oq.size(), 384);
    chk($sformatf("%s_done_pulses", tag), done_cnt, 1);
    chk($sformatf("%s_done_latency", tag), done_at - last_hs, 1);
    chk($sformatf("%s_busy_at_done", tag), busy_at_done, 0);
    chk($sformatf("%s_busy_after", tag), busy, 0);
    bad = 0;
    nlast = 0;
    for (int i = 0; i < oq.size() && i < slq.size(); i++) begin
      if (lq[i] != slq[i]) bad++;
      if (lq[i]) nlast++;
    end
    chk($sformatf("%s_out_last_align", tag), bad, 0);
    chk($sformatf("%s_out_last_count", tag), nlast, (tag == "C") ? 7 : 6);
  endtask

  initial begin
    int bad;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_cur_shift", cur_shift, 0);
    chk("rst_blk_exp", blk_exp, 0);
    chk("rst_frame_err", frame_err, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", in_ready, 0);

    // A: directed shifts and rounding
    start_xfer();
    chk("A_busy", busy, 1);
    for (int i = 0; i < 64; i++) begin
      send((i == 0) ? 12000 : 0, i == 63);
      if (i == 0) chk("A_lat_stage1", out_valid, 0);
      if (i == 1) begin
        chk("A_lat_valid", out_valid, 1);
        chk("A_lat_data", out_data, 12000);
      end
    end
    chk("A_f0_shift", cur_shift, 1);  chk("A_f0_exp", blk_exp, 0);
    send_frame(3, 5, -3, -5, 0);
    chk("A_f1_shift", cur_shift, 0);  chk("A_f1_exp", blk_exp, 1);
    send_frame(16384, 0, 0, 0, 0);
    chk("A_f2_shift", cur_shift, 2);  chk("A_f2_exp", blk_exp, 1);
    send_frame(6, 10, 32767, -32768, 0);
    chk("A_f3_shift", cur_shift, 1);  chk("A_f3_exp", blk_exp, 3);
    send_frame(-32768, 0, 0, 0, 0);
    chk("A_f4_shift", cur_shift, 1);  chk("A_f4_exp", blk_exp, 4);
    send_frame(16382, 0, 0, 0, 0);
    chk("A_f5_shift", cur_shift, 0);  chk("A_f5_exp", blk_exp, 5);
    wait_done("A");
    if (oq.size() > 320) begin
      chk("A_pass_12000", oq[0], 12000);
      chk("A_s1_p3", oq[64], 2);     chk("A_s1_p5", oq[65], 2);
      chk("A_s1_m3", oq[66], -2);    chk("A_s1_m5", oq[67], -2);
      chk("A_pass_16384", oq[128], 16384);
      chk("A_s2_6", oq[192], 2);     chk("A_s2_10", oq[193], 2);
      chk("A_s2_max", oq[194], 8192); chk("A_s2_min", oq[195], -8192);
      chk("A_s1_min", oq[256], -16384);
      chk("A_s1_16382", oq[320], 8191);
    end

    // B: random backpressure, start while busy
    rnd_rdy = 1'b1;
    start_xfer();
    send_frame(0, 0, 0, 0, 1);
    send_frame(0, 0, 0, 0, 1);
    send_frame(0, 0, 0, 0, 1);
    in_valid = 1'b0;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk("B_start_ignored_busy", busy, 1);
    chk("B_start_ignored_exp", blk_exp, 0);
    send_frame(0, 0, 0, 0, 1);
    send_frame(0, 0, 0, 0, 1);
    send_frame(0, 0, 0, 0, 1);
    wait_done("B");
    bad = 0;
    for (int i = 0; i < oq.size() && i < sq.size(); i++) begin
      if (oq[i] != sq[i]) bad++;
    end
    chk("B_data_mismatches", bad, 0);
    chk("B_shift", cur_shift, 0);
    rnd_rdy = 1'b0;

    // C: early in_last
    start_xfer();
    for (int i = 0; i < 64; i++) begin
      send((i == 0) ? 12000 : 0, (i == 10) || (i == 63));
      if (i == 9) chk("C_err_before", frame_err, 0);
      if (i == 10) begin
        chk("C_err_set", frame_err, 1);
        chk("C_no_early_boundary", cur_shift, 0);
      end
    end
    chk("C_boundary_63", cur_shift, 1);
    for (int f = 1; f < 6; f++) send_frame(0, 0, 0, 0, 0);
    wait_done("C");
    chk("C_err_sticky", frame_err, 1);
    chk("C_exp", blk_exp, 1);

    // D: next start clears error, then reset mid-frame 3
    start_xfer();
    chk("D_err_cleared", frame_err, 0);
    chk("D_exp_cleared", blk_exp, 0);
    send_frame(16384, 0, 0, 0, 0);
    chk("D_f0_shift", cur_shift, 2);
    send_frame(0, 0, 0, 0, 0);
    chk("D_f1_exp", blk_exp, 2);
    send_frame(0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) send(100 + i, 1'b0);
    chk("D_pre_rst_valid", out_valid, 1);
    rst = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("D_rst_busy", busy, 0);
    chk("D_rst_in_ready", in_ready, 0);
    chk("D_rst_out_valid", out_valid, 0);
    chk("D_rst_out_data", out_data, 0);
    chk("D_rst_out_last", out_last, 0);
    chk("D_rst_exp", blk_exp, 0);
    chk("D_rst_shift", cur_shift, 0);
    rst = 1'b0;
    @(negedge clk);

    // E: clean transform after reset
    start_xfer();
    send_frame(12000, 0, 0, 0, 0);
    chk("E_f0_shift", cur_shift, 1);
    chk("E_f0_exp", blk_exp, 0);
    for (int f = 1; f < 6; f++) send_frame(0, 0, 0, 0, 0);
    wait_done("E");
    chk("E_exp", blk_exp, 1);
    chk("E_err", frame_err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fft_bfp_scaler.md
Name: fft_bfp_scaler

Overview:
Block-floating-point scaling controller placed after each FFT butterfly stage.
- Streams one stage frame of samples through a round-half-to-even right-shifter.
- Measures the peak magnitude of the frame to choose the shift for the next frame.
- Accumulates the total block exponent over all stages of one transform.
- Sequences NUM_STAGES frames per start command and reports completion.

Parameters:
- DATA_W, 16: signed sample width, input and output (shifting never grows width).
- FRAME_LEN, 64: samples per stage frame.
- NUM_STAGES, 6: frames per transform.
- GUARD, 2: required headroom bits; peak must fit in DATA_W-GUARD signed bits for zero shift.
- EXP_W, 8: width of the accumulated exponent.

Ports:
- clk in 1: clock.
- rst in 1: synchronous, active-high reset.
- start in 1: one-cycle pulse; begins a transform; ignored unless idle.
- busy out 1: high from accepted start until done.
- done out 1: one-cycle pulse after the last sample of the last frame leaves the output.
- in_valid in 1: input sample valid.
- in_ready out 1: input accept.
- in_data in DATA_W: signed sample.
- in_last in 1: marks the last sample of a frame.
- out_valid out 1: output sample valid.
- out_ready in 1: downstream accept.
- out_data out DATA_W: rounded, shifted sample.
- out_last out 1: in_last delayed with its sample.
- cur_shift out 2: shift applied to the current frame (0..2).
- blk_exp out EXP_W: sum of shifts applied since start.
- frame_err out 1: sticky flag; in_last disagreed with the frame counter.

Behaviour:
- Reset values: all outputs 0; state IDLE; shift 0; peak class 0; counters 0.
- FSM states:
  - IDLE: in_ready=0. On start, go to RUN; clear blk_exp, frame_err, frame counter, stage counter; set shift=0.
  - RUN: stream samples (rules below).
  - DRAIN: in_ready=0 until the pipeline is empty, then pulse done and go to IDLE.
- Pipeline: 2 register stages, S1 = round/shift, S2 = output register. Latency is 2 cycles from acceptance to out_valid when there is no backpressure.
- Advance rule: adv = !out_valid || out_ready. Both stages move only when adv. in_ready = (state==RUN) && adv. Zero bubbles under continuous valid/ready.
- Rounding for shift s:
  - s=0: pass through unchanged.
  - s>0: compute in DATA_W+1 bits: t = x + (2^(s-1) - 1) + x[s]; result = t >>> s, truncated to DATA_W. The result is always in range.
  - Ties go to the even result; signed values are handled symmetrically.
- Peak class is computed on each output value y:
  - 0 if y fits in DATA_W-GUARD signed bits;
  - 1 if y fits in DATA_W-GUARD+1 signed bits;
  - else 2.
  - A running max class is kept over the frame, including the last sample combinationally.
- Frame end: on acceptance of a sample where the frame counter reaches FRAME_LEN-1, in the same cycle:
  - next shift = frame max class;
  - blk_exp += current shift, saturating at all-ones;
  - peak and frame counter clear;
  - stage counter increments.
  - The following sample uses the new shift; there is no bubble.
- Frame errors: if in_last is asserted at a count other than FRAME_LEN-1, or is missing at FRAME_LEN-1, frame_err sets (sticky until the next start). The counter alone defines frame boundaries.
- After the stage counter reaches NUM_STAGES, go to DRAIN.
- start while busy: ignored.
- rst mid-frame: immediate return to reset values; in-flight samples are discarded.
- cur_shift is visible from the cycle after the update.

Optional Feature:
FFT_BFP_FORCE_SHIFT_EN
- Defined: adds input ports force_en (1) and force_shift (2). When force_en=1 at a frame boundary, force_shift (clamped to 2) replaces the peak-derived shift. blk_exp accumulates the forced value.
- Undefined: the ports are absent and the shift is always peak-derived.

Decomposition:
- Shared package fft_pkg holds:
  - the state enum (IDLE/RUN/DRAIN);
  - the shift type (2-bit);
  - MAX_SHIFT=2;
  - the peak-class helper function.
- One natural sub-module: bfp_round_shift. It is the combinational variable-shift round-half-to-even unit, instantiated inside the S1 stage.

Test Plan:
- DATA_W=16, shift forced to 1 via a frame with peak 12000 (class 1). Next frame inputs 3, 5, -3, -5 give outputs 2, 2, -2, -2.
- Shift 2: inputs 6, 10, 32767, -32768 give outputs 2, 2, 8192, -8192. No overflow occurs.
- Frame peak 8191 gives next shift 0. Peak 8192 gives shift 1. Peak 16384 gives shift 2. Peak -16384 gives shift 1. Check blk_exp increments accordingly.
- Full transform with FRAME_LEN=64, NUM_STAGES=6, out_ready toggling randomly:
  - exactly 384 outputs, out_last every 64th;
  - done pulses once, 1 cycle after the final output handshake;
  - busy drops with done.
- in_last asserted at sample 10: frame_err=1, boundary still at sample 63. Next start clears frame_err.
- rst asserted mid-frame 3: all outputs 0 next cycle. A new start runs cleanly with blk_exp starting from 0.
